imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory. Drives imem write port A, the port the core leaves tied off; the core fetches on port B.
- Accepts a byte stream over a valid/ready handshake from a UART/debug front end.
- Assembles little-endian 32-bit words and writes them to consecutive word addresses.
- Holds the core in reset until a complete image has been loaded.

Parameters:
- IMEM_DEPTH, 1024, number of 32-bit words in imem; the largest image that is accepted.
- ADDR_W, 32, width of imem_addra; carries a word address, matching the core's PC>>2 indexing.

Ports:
- pad_clk  in  1  single clock for all logic.
- pad_rst_n  in  1  asynchronous active-low reset.
- byte_valid  in  1  source presents byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- reload_req  in  1  single-cycle pulse; restarts loading from DONE or ERR.
- imem_ena  out  1  imem port A enable.
- imem_wea  out  1  imem port A write enable.
- imem_addra  out  ADDR_W  imem word address.
- imem_dia  out  32  imem write data.
- core_rst_n  out  1  active-low reset to the core.
- load_done  out  1  image loaded; the core is running.
- load_err  out  1  load aborted.

Behaviour:
- Clock and reset: one clock, pad_clk. Reset pad_rst_n is asynchronous and active-low. All state is registered.
- Reset values:
  - state = S_LEN; byte_ready = 1.
  - imem_ena = 0, imem_wea = 0, imem_addra = 0, imem_dia = 0.
  - core_rst_n = 0, load_done = 0, load_err = 0.
  - Byte counter, word counter and length register = 0.
- Accept rule: a byte is accepted when byte_valid && byte_ready. byte_ready depends only on state, never on byte_valid.
- Stream format:
  - 4-byte little-endian word count N.
  - N words, 4 bytes each, little-endian (first byte is bits [7:0]).
- States:
  - S_LEN: collect 4 bytes into N. After the 4th byte:
    - N == 0 → S_DONE.
    - N > IMEM_DEPTH → S_ERR.
    - otherwise → S_DATA.
  - S_DATA: shift bytes into a word buffer. The cycle after the 4th byte of a word is accepted, pulse imem_ena = imem_wea = 1 for exactly one cycle, with imem_addra = word counter and imem_dia = assembled word. The word counter then increments.
    - byte_ready stays 1 during the write pulse; the write path is fully pipelined.
    - After word N-1 is accepted → S_DONE (or S_CHK when the checksum option is compiled in). The final write pulse still occurs in the following cycle.
  - S_DONE: byte_ready = 0, load_done = 1, core_rst_n = 1. core_rst_n rises one cycle after the final write pulse, so the last word is in imem before the first fetch.
  - S_ERR: byte_ready = 0, load_err = 1, core_rst_n = 0.
- reload_req:
  - In S_DONE or S_ERR: next cycle core_rst_n = 0, load_done = 0, load_err = 0, all counters cleared, state = S_LEN.
  - Ignored in S_LEN, S_DATA and S_CHK.
- Idle gaps: byte_valid low for any number of cycles stalls the stream; no timeout.
- Reset mid-load: asynchronous return to the reset state. imem contents are not cleared, and a partial image is never executed because core_rst_n stays 0.
- Arithmetic: counters are 32 bits wide. The N > IMEM_DEPTH comparison is unsigned. imem_addra is the word counter zero-extended or truncated to ADDR_W.
- The imem port-A clock is pad_clk, driven at the top level, not by this block.

Optional Feature:
- Macro: IMEM_LOADER_CHKSUM_EN.
- With the macro defined:
  - After the data words, state S_CHK collects a 4-byte little-endian checksum.
  - Expected value: mod-2^32 sum of all N data words, accumulated as each word is written.
  - Match → S_DONE. Mismatch → S_ERR.
  - N == 0 still expects a checksum of 0.
- Without the macro: there is no S_CHK and no accumulator; the last data word goes directly to S_DONE.

Decomposition:
- Shared package holds:
  - State encodings S_LEN, S_DATA, S_CHK, S_DONE, S_ERR.
  - LOADER_WORD_BYTES = 4.
  - Data width constant shared with the existing 32-bit instruction/data width definitions.
- One natural sub-module: byte2word_pack. It takes an accepted byte plus a clear input and outputs the packed 32-bit word and a word_valid pulse. The FSM reuses it for the length, data and checksum fields.

Test Plan:
- Reset: after reset, byte_ready = 1, core_rst_n = 0, no imem write pulses.
- Nominal load: stream 02 00 00 00, 13 00 00 00, 93 00 10 00 → writes addr 0 = 0x00000013 and addr 1 = 0x00100093, one-cycle wea each. core_rst_n rises one cycle after the second write; load_done = 1.
- Back-pressure and gaps: same image with byte_valid toggled 1-0-0-1 between bytes → identical writes and data; no duplicated or dropped bytes.
- Length checks:
  - N = 0x00000401 with IMEM_DEPTH = 1024 → S_ERR: load_err = 1, byte_ready = 0, no writes, core stays in reset.
  - N = 0 → S_DONE immediately.
- Reload and mid-load reset:
  - From DONE, pulse reload_req → core_rst_n = 0 next cycle; a new 1-word load to addr 0 succeeds.
  - Assert pad_rst_n low after 5 of 8 data bytes → outputs return to reset values immediately.
- Checksum (IMEM_LOADER_CHKSUM_EN): words 0x00000013 and 0x00100093 with checksum A6 00 10 00 → DONE. Same words with checksum A7 00 10 00 → ERR with core_rst_n = 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the imem boot loader.
// Optional checksum stage is enabled with `define IMEM_LOADER_CHKSUM_EN.
package imem_loader_pkg;

    localparam int unsigned DATA_W            = 32;
    localparam int unsigned LOADER_WORD_BYTES = 4;
    localparam int unsigned BYTE_IDX_W        = $clog2(LOADER_WORD_BYTES);

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CHK  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } loader_state_t;

    // Terminal states are the only ones that honour reload_req.
    function automatic logic is_terminal(input loader_state_t s);
        return (s == S_DONE) || (s == S_ERR);
    endfunction

endpackage

// File: rtl/imem_loader_byte2word_pack.sv
// Little-endian byte-to-word packer; word_valid fires in the cycle the last byte of a word is accepted.
module imem_loader_byte2word_pack
    import imem_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_byte_en,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_valid
);

    logic [BYTE_IDX_W-1:0] r_idx;
    logic [DATA_W-1:0]     r_shift;
    logic [DATA_W-1:0]     w_word;

    // Bytes shift in from the top so the first byte lands in bits [7:0].
    assign w_word       = {i_byte, r_shift[DATA_W-1:8]};
    assign o_word       = w_word;
    assign o_word_valid = i_byte_en && (r_idx == BYTE_IDX_W'(LOADER_WORD_BYTES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_clr) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_byte_en) begin
            r_idx   <= r_idx + 1'b1;
            r_shift <= w_word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time imem port-A writer: length-prefixed byte stream in, word writes out, core held in reset until done.
// Define IMEM_LOADER_CHKSUM_EN to require a trailing mod-2^32 word-sum checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              pad_clk,
    input  logic              pad_rst_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              reload_req,
    output logic              imem_ena,
    output logic              imem_wea,
    output logic [ADDR_W-1:0] imem_addra,
    output logic [31:0]       imem_dia,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_err
);

    loader_state_t     r_state;
    logic              r_byte_ready;
    logic              r_imem_ena;
    logic              r_imem_wea;
    logic [ADDR_W-1:0] r_imem_addra;
    logic [31:0]       r_imem_dia;
    logic              r_core_rst_n;
    logic              r_load_done;
    logic              r_load_err;
    logic [31:0]       r_len;
    logic [31:0]       r_word_cnt;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [31:0]       r_sum;
`endif

    logic              w_byte_acc;
    logic              w_reload;
    logic              w_last_word;
    logic [DATA_W-1:0] w_word;
    logic              w_word_valid;

    assign w_byte_acc  = byte_valid && r_byte_ready;
    assign w_reload    = reload_req && is_terminal(r_state);
    assign w_last_word = (r_word_cnt == (r_len - 32'd1));

    imem_loader_byte2word_pack u_pack (
        .i_clk        (pad_clk),
        .i_rst_n      (pad_rst_n),
        .i_clr        (w_reload),
        .i_byte_en    (w_byte_acc),
        .i_byte       (byte_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge pad_clk or negedge pad_rst_n) begin
        if (!pad_rst_n) begin
            r_state      <= S_LEN;
            r_byte_ready <= 1'b1;
            r_imem_ena   <= 1'b0;
            r_imem_wea   <= 1'b0;
            r_imem_addra <= '0;
            r_imem_dia   <= '0;
            r_core_rst_n <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_len        <= '0;
            r_word_cnt   <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            r_imem_ena <= 1'b0;
            r_imem_wea <= 1'b0;
            case (r_state)
                S_LEN: begin
                    if (w_word_valid) begin
                        r_len <= w_word;
                        if (w_word == '0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                            r_state      <= S_CHK;
`else
                            r_state      <= S_DONE;
                            r_byte_ready <= 1'b0;
`endif
                        end else if (w_word > 32'(IMEM_DEPTH)) begin
                            r_state      <= S_ERR;
                            r_byte_ready <= 1'b0;
                            r_load_err   <= 1'b1;
                        end else begin
                            r_state      <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_word_valid) begin
                        r_imem_ena   <= 1'b1;
                        r_imem_wea   <= 1'b1;
                        r_imem_addra <= ADDR_W'(r_word_cnt);
                        r_imem_dia   <= w_word;
                        r_word_cnt   <= r_word_cnt + 32'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
                        r_sum        <= r_sum + w_word;
                        if (w_last_word) begin
                            r_state <= S_CHK;
                        end
`else
                        if (w_last_word) begin
                            r_state      <= S_DONE;
                            r_byte_ready <= 1'b0;
                        end
`endif
                    end
                end
`ifdef IMEM_LOADER_CHKSUM_EN
                S_CHK: begin
                    if (w_word_valid) begin
                        r_byte_ready <= 1'b0;
                        if (w_word == r_sum) begin
                            r_state    <= S_DONE;
                        end else begin
                            r_state    <= S_ERR;
                            r_load_err <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    // Release lags DONE entry by a cycle so the final write lands before the first fetch.
                    if (w_reload) begin
                        r_state      <= S_LEN;
                        r_byte_ready <= 1'b1;
                        r_core_rst_n <= 1'b0;
                        r_load_done  <= 1'b0;
                        r_load_err   <= 1'b0;
                        r_len        <= '0;
                        r_word_cnt   <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
                        r_sum        <= '0;
`endif
                    end else begin
                        r_core_rst_n <= 1'b1;
                        r_load_done  <= 1'b1;
                    end
                end
                S_ERR: begin
                    r_core_rst_n <= 1'b0;
                    if (w_reload) begin
                        r_state      <= S_LEN;
                        r_byte_ready <= 1'b1;
                        r_load_done  <= 1'b0;
                        r_load_err   <= 1'b0;
                        r_len        <= '0;
                        r_word_cnt   <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
                        r_sum        <= '0;
`endif
                    end
                end
                default: begin
                    r_state      <= S_LEN;
                    r_byte_ready <= 1'b1;
                end
            endcase
        end
    end

    assign byte_ready = r_byte_ready;
    assign imem_ena   = r_imem_ena;
    assign imem_wea   = r_imem_wea;
    assign imem_addra = r_imem_addra;
    assign imem_dia   = r_imem_dia;
    assign core_rst_n = r_core_rst_n;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes come from parsing the byte stream.
module tb_imem_loader;

    localparam int unsigned DEPTH = 1024;

    logic        pad_clk = 1'b0;
    logic        pad_rst_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        reload_req;
    logic        imem_ena;
    logic        imem_wea;
    logic [31:0] imem_addra;
    logic [31:0] imem_dia;
    logic        core_rst_n;
    logic        load_done;
    logic        load_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          cyc         = 0;
    int          last_wr_cyc = -1;
    int          rise_cyc    = -1;
    logic        prev_crst   = 1'b0;

    always #5 pad_clk = ~pad_clk;

    imem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(32)) dut (
        .pad_clk    (pad_clk),
        .pad_rst_n  (pad_rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .reload_req (reload_req),
        .imem_ena   (imem_ena),
        .imem_wea   (imem_wea),
        .imem_addra (imem_addra),
        .imem_dia   (imem_dia),
        .core_rst_n (core_rst_n),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge pad_clk) cyc <= cyc + 1;

    // Write monitor: every port-A pulse must match the next expected (addr, data).
    always @(posedge pad_clk) begin
        #1;
        if (imem_ena || imem_wea) chk("ena_eq_wea", imem_wea, imem_ena);
        if (imem_wea) begin
            if (exp_addr_q.size() == 0) begin
                chk("spurious_write", 1, 0);
            end else begin
                chk("wr_addr", imem_addra, exp_addr_q.pop_front());
                chk("wr_data", imem_dia, exp_data_q.pop_front());
            end
            last_wr_cyc = cyc;
        end
        if (core_rst_n && !prev_crst) rise_cyc = cyc;
        prev_crst = core_rst_n;
    end

    function automatic logic [31:0] le32(input logic [7:0] q[$], input int base);
        return {q[base+3], q[base+2], q[base+1], q[base]};
    endfunction

    // Reference: parse the stream and decide outcome plus the writes it must cause.
    task automatic model(input logic [7:0] q[$], output bit exp_done, output bit exp_err);
        logic [31:0] n;
        logic [31:0] sum;
        n = le32(q, 0);
        sum = 32'd0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (n > DEPTH) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                exp_addr_q.push_back(32'(i));
                exp_data_q.push_back(le32(q, 4 + 4*i));
                sum += le32(q, 4 + 4*i);
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            if (le32(q, 4 + 4*int'(n)) == sum) exp_done = 1'b1;
            else exp_err = 1'b1;
`else
            exp_done = 1'b1;
`endif
        end
    endtask

    task automatic make_stream(input logic [31:0] n, input bit bad_cs, output logic [7:0] q[$]);
        logic [31:0] w;
        logic [31:0] sum;
        q = {};
        sum = 32'd0;
        for (int b = 0; b < 4; b++) q.push_back(8'(n >> (8*b)));
        if (n <= DEPTH) begin
            for (int i = 0; i < int'(n); i++) begin
                w = $urandom;
                sum += w;
                for (int b = 0; b < 4; b++) q.push_back(8'(w >> (8*b)));
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            if (bad_cs) sum += 32'd1;
            for (int b = 0; b < 4; b++) q.push_back(8'(sum >> (8*b)));
`else
            if (bad_cs) sum = 32'd0;
`endif
        end
    endtask

    // Entered and left at a negedge; gaps hold byte_valid low.
    task automatic send(input logic [7:0] q[$], input int gap_max);
        int t;
        foreach (q[i]) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge pad_clk);
            byte_valid = 1'b1;
            byte_data  = q[i];
            t = 0;
            while (!byte_ready && t < 20) begin
                @(negedge pad_clk);
                t++;
            end
            chk("ready_wait", (t < 20), 1);
            if (t >= 20) begin
                byte_valid = 1'b0;
                return;
            end
            @(negedge pad_clk);
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
        end
    endtask

    task automatic do_reload();
        @(negedge pad_clk);
        reload_req = 1'b1;
        @(negedge pad_clk);
        reload_req = 1'b0;
        chk("reload_core_rst_n", core_rst_n, 0);
        chk("reload_done", load_done, 0);
        chk("reload_err", load_err, 0);
        chk("reload_ready", byte_ready, 1);
    endtask

    task automatic run(input logic [7:0] q[$], input int gap_max);
        bit d;
        bit e;
        int t;
        logic [31:0] n;
        n = le32(q, 0);
        model(q, d, e);
        rise_cyc = -1;
        send(q, gap_max);
        t = 0;
        while (!(load_done || load_err) && t < 50) begin
            @(negedge pad_clk);
            t++;
        end
        chk("end_reached", (t < 50), 1);
        @(negedge pad_clk);
        chk("load_done", load_done, d);
        chk("load_err", load_err, e);
        chk("core_rst_n", core_rst_n, d);
        chk("ready_low_at_end", byte_ready, 0);
        chk("writes_left", exp_addr_q.size(), 0);
`ifndef IMEM_LOADER_CHKSUM_EN
        if (d && n != 0) chk("crst_rise_lat", rise_cyc - last_wr_cyc, 1);
`endif
        do_reload();
        exp_addr_q = {};
        exp_data_q = {};
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] part[$];
        pad_rst_n  = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        reload_req = 1'b0;
        #1 pad_rst_n = 1'b0;
        repeat (3) @(negedge pad_clk);
        chk("rst_ready", byte_ready, 1);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_ena", imem_ena, 0);
        chk("rst_wea", imem_wea, 0);
        chk("rst_addra", imem_addra, 0);
        chk("rst_dia", imem_dia, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        pad_rst_n = 1'b1;
        repeat (2) @(negedge pad_clk);

        // Nominal image, then with gaps.
        q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CHKSUM_EN
        q.push_back(8'hA6); q.push_back(8'h00); q.push_back(8'h10); q.push_back(8'h00);
`endif
        run(q, 0);
        run(q, 2);
`ifdef IMEM_LOADER_CHKSUM_EN
        q[12] = 8'hA7;
        run(q, 1);
`endif

        // Length boundaries.
        q = '{8'h01, 8'h04, 8'h00, 8'h00};
        run(q, 1);
        q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run(q, 0);
        make_stream($urandom_range(32'hFFFF, DEPTH + 1), 1'b0, q);
        run(q, 1);
        make_stream(32'd0, 1'b0, q);
        run(q, 0);

        for (int k = 0; k < 8; k++) begin
            make_stream($urandom_range(8, 1), 1'($urandom_range(3, 0) == 0), q);
            run(q, int'($urandom_range(3, 0)));
        end

        make_stream(32'(DEPTH), 1'b0, q);
        run(q, 0);

        // Mid-load reset after 5 of 8 data bytes.
        make_stream(32'd2, 1'b0, q);
        begin
            bit d;
            bit e;
            model(q, d, e);
        end
        part = {};
        for (int i = 0; i < 9; i++) part.push_back(q[i]);
        send(part, 0);
        pad_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", byte_ready, 1);
        chk("mid_rst_core_rst_n", core_rst_n, 0);
        chk("mid_rst_ena", imem_ena, 0);
        chk("mid_rst_wea", imem_wea, 0);
        chk("mid_rst_addra", imem_addra, 0);
        chk("mid_rst_dia", imem_dia, 0);
        chk("mid_rst_done", load_done, 0);
        chk("mid_rst_writes_seen", exp_addr_q.size(), 1);
        exp_addr_q = {};
        exp_data_q = {};
        @(negedge pad_clk);
        pad_rst_n = 1'b1;
        @(negedge pad_clk);

        make_stream(32'd1, 1'b0, q);
        run(q, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
